// File: rtl/msdap_pkg.sv
// Shared types and widths for the MSDAP frame scheduler: FSM states, ALU channel
// select, datapath widths.
package msdap_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CLR_L,
        RUN_L,
        CLR_R,
        RUN_R,
        PUSH,
        SLEEP
    } state_t;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } chan_t;

    function automatic logic is_zero_pair(input logic [DATA_W-1:0] l,
                                          input logic [DATA_W-1:0] r);
        return (l == '0) && (r == '0);
    endfunction

endpackage

// File: rtl/msdap_alu_scheduler_if.sv
// Bus bundle between the frame scheduler and its surroundings: sample intake,
// data-memory write port, ALU control and the result output port.
interface msdap_alu_scheduler_if;
    import msdap_pkg::*;

    logic              sample_valid;
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;

    logic [1:0]        dmem_we;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0] dmem_wdata_l;
    logic [DATA_W-1:0] dmem_wdata_r;

    logic              alu_clear;
    logic              alu_enable;
    chan_t             alu_chan;
    logic [ADDR_W-1:0] alu_cur_addr;
    logic              alu_output_en;
    logic [ACC_W-1:0]  alu_result;

    // out_valid/out_ready: the pair transfers on a rising edge where both are 1;
    // out_l/out_r hold steady while out_valid waits for out_ready.
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_l;
    logic [ACC_W-1:0]  out_r;

    logic              overrun;
    logic              timeout_err;
    logic              sleep;

    modport master (
        input  sample_valid, sample_l, sample_r, alu_output_en, alu_result, out_ready,
        output dmem_we, dmem_waddr, dmem_wdata_l, dmem_wdata_r,
               alu_clear, alu_enable, alu_chan, alu_cur_addr,
               out_valid, out_l, out_r, overrun, timeout_err, sleep
    );

    modport slave (
        output sample_valid, sample_l, sample_r, alu_output_en, alu_result, out_ready,
        input  dmem_we, dmem_waddr, dmem_wdata_l, dmem_wdata_r,
               alu_clear, alu_enable, alu_chan, alu_cur_addr,
               out_valid, out_l, out_r, overrun, timeout_err, sleep
    );

endinterface

// File: rtl/zero_run_detector.sv
// Saturating count of consecutive all-zero frames; flags when the count after
// this update equals ZERO_RUN.
module zero_run_detector #(
    parameter int ZERO_RUN = 800
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic is_zero,
    output logic reached_next
);

    localparam int CW = $clog2(ZERO_RUN + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (en) begin
            if (!is_zero)
                cnt_next = '0;
            else if (cnt != CW'(ZERO_RUN))
                cnt_next = cnt + 1'b1;
        end
    end

    assign reached_next = (cnt_next == CW'(ZERO_RUN));

    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

endmodule

// File: rtl/msdap_alu_scheduler.sv
// Frame controller for the shared filter ALU: writes each stereo pair, runs the
// left then right channel, and offers the result pair on a valid/ready port.
module msdap_alu_scheduler
    import msdap_pkg::*;
#(
    parameter int ZERO_RUN = 800,
    parameter int TIMEOUT  = 4095
) (
    input  logic                  clk,
    input  logic                  clear,
    msdap_alu_scheduler_if.master bus,
    output state_t                state_dbg,
    output logic [ADDR_W-1:0]     wr_ptr_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] wr_ptr, cur_addr;
    logic              pending, sleep_q, overrun_q, timeout_q;
    logic [DATA_W-1:0] pend_l, pend_r, cur_l, cur_r;
    logic [ACC_W-1:0]  out_l_q, out_r_q;
    logic [TW-1:0]     wait_cnt;
    logic              intake, zero_pair, timed_out, run_done, zero_reached;

    assign intake    = (state == IDLE) || (state == SLEEP);
    assign zero_pair = is_zero_pair(cur_l, cur_r);
    assign timed_out = (wait_cnt == TW'(TIMEOUT - 1));
    assign run_done  = bus.alu_output_en || timed_out;

    zero_run_detector #(.ZERO_RUN(ZERO_RUN)) u_zero (
        .clk          (clk),
        .clear        (clear),
        .en           (state == WRITE),
        .is_zero      (zero_pair),
        .reached_next (zero_reached)
    );

    always_comb begin
        state_next       = state;
        bus.dmem_we      = 2'b00;
        bus.dmem_waddr   = '0;
        bus.dmem_wdata_l = '0;
        bus.dmem_wdata_r = '0;
        bus.alu_clear    = 1'b0;
        bus.alu_enable   = 1'b0;
        bus.alu_chan     = CH_L;
        bus.out_valid    = 1'b0;
        case (state)
            IDLE, SLEEP: if (pending || bus.sample_valid) state_next = WRITE;
            WRITE: begin
                bus.dmem_we      = 2'b11;
                bus.dmem_waddr   = wr_ptr;
                bus.dmem_wdata_l = cur_l;
                bus.dmem_wdata_r = cur_r;
                // In sleep a zero frame bypasses the ALU and pushes 0/0.
                if (sleep_q)
                    state_next = zero_pair ? PUSH : CLR_L;
                else
                    state_next = zero_reached ? SLEEP : CLR_L;
            end
            CLR_L: begin
                bus.alu_clear = 1'b1;
                state_next    = RUN_L;
            end
            RUN_L: begin
                bus.alu_enable = 1'b1;
                if (run_done) state_next = CLR_R;
            end
            CLR_R: begin
                bus.alu_clear = 1'b1;
                bus.alu_chan  = CH_R;
                state_next    = RUN_R;
            end
            RUN_R: begin
                bus.alu_enable = 1'b1;
                bus.alu_chan   = CH_R;
                if (run_done) state_next = PUSH;
            end
            PUSH: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = sleep_q ? SLEEP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr    <= '0;
            cur_addr  <= '0;
            pending   <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
            cur_l     <= '0;
            cur_r     <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            wait_cnt  <= '0;
            sleep_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            // A pending pair is older than any new arrival, so it is consumed first.
            if (intake) begin
                if (pending) begin
                    cur_l   <= pend_l;
                    cur_r   <= pend_r;
                    pending <= bus.sample_valid;
                    if (bus.sample_valid) begin
                        pend_l <= bus.sample_l;
                        pend_r <= bus.sample_r;
                    end
                end else if (bus.sample_valid) begin
                    cur_l <= bus.sample_l;
                    cur_r <= bus.sample_r;
                end
            end else if (bus.sample_valid) begin
                if (!pending) begin
                    pending <= 1'b1;
                    pend_l  <= bus.sample_l;
                    pend_r  <= bus.sample_r;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            case (state)
                WRITE: begin
                    cur_addr <= wr_ptr;
                    wr_ptr   <= wr_ptr + 1'b1;
                    if (sleep_q) begin
                        if (zero_pair) begin
                            out_l_q <= '0;
                            out_r_q <= '0;
                        end else begin
                            sleep_q <= 1'b0;
                        end
                    end else if (zero_reached) begin
                        sleep_q <= 1'b1;
                    end
                end
                CLR_L, CLR_R: wait_cnt <= '0;
                RUN_L, RUN_R: begin
                    if (bus.alu_output_en) begin
                        if (state == RUN_L) out_l_q <= bus.alu_result;
                        else                out_r_q <= bus.alu_result;
                    end else if (timed_out) begin
                        if (state == RUN_L) out_l_q <= '0;
                        else                out_r_q <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_cur_addr = cur_addr;
    assign bus.out_l        = out_l_q;
    assign bus.out_r        = out_r_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout_err  = timeout_q;
    assign bus.sleep        = sleep_q;
    assign state_dbg        = state;
    assign wr_ptr_dbg       = wr_ptr;

endmodule

// File: tb/tb_msdap_alu_scheduler.sv
// Directed bench for msdap_alu_scheduler with a behavioural ALU and an
// expected-result queue checked at every output handshake.
module tb_msdap_alu_scheduler;
    import msdap_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    state_t            dut_state;
    logic [ADDR_W-1:0] dut_wr_ptr;

    msdap_alu_scheduler_if bus ();

    msdap_alu_scheduler #(.ZERO_RUN(800), .TIMEOUT(4095)) dut (
        .clk        (clk),
        .clear      (clear),
        .bus        (bus),
        .state_dbg  (dut_state),
        .wr_ptr_dbg (dut_wr_ptr)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- ALU model ----------------
    int               alu_lat  = 20;
    bit               alu_hang = 1'b0;
    logic [15:0]      alu_cnt  = '0;
    logic [ACC_W-1:0] res_l    = '0;
    logic [ACC_W-1:0] res_r    = '0;

    always @(posedge clk) begin
        if (bus.alu_clear)
            alu_cnt <= '0;
        else if (bus.alu_enable && !bus.alu_output_en)
            alu_cnt <= alu_cnt + 16'd1;
    end
    assign bus.alu_output_en = bus.alu_enable && !alu_hang && (alu_cnt == 16'(alu_lat - 1));
    assign bus.alu_result    = (bus.alu_chan == CH_R) ? res_r : res_l;

    // ---------------- event monitors ----------------
    int   en_rises = 0, clr_viol = 0, en_high = 0, ov_cnt = 0;
    logic prev_en = 1'b0, prev_clr = 1'b0;

    always @(negedge clk) begin
        if (bus.alu_enable && !prev_en) begin
            en_rises <= en_rises + 1;
            if (!prev_clr) clr_viol <= clr_viol + 1;
        end
        if (bus.alu_enable) en_high <= en_high + 1;
        if (bus.overrun)    ov_cnt  <= ov_cnt + 1;
        prev_en  <= bus.alu_enable;
        prev_clr <= bus.alu_clear;
    end

    // ---------------- scoreboard ----------------
    logic [2*ACC_W-1:0] exp_q[$];
    logic [2*ACC_W-1:0] sb_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!clear && bus.out_valid && bus.out_ready) begin
            check("sb_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check("sb_out_l", 64'(bus.out_l), 64'(sb_e[2*ACC_W-1:ACC_W]));
                check("sb_out_r", 64'(bus.out_r), 64'(sb_e[ACC_W-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        bus.sample_l     = l;
        bus.sample_r     = r;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int max_cyc, input string tag);
        int n = 0;
        while (dut_state !== s && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 64'(dut_state), 64'(s));
    endtask

    // ---------------- directed sequence ----------------
    logic [ADDR_W-1:0] exp_ptr;
    int snap_a, snap_b, bad;

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_l     = '0;
        bus.sample_r     = '0;
        bus.out_ready    = 1'b0;

        // reset state
        clear = 1'b1;
        ticks(3);
        check("rst_state", 64'(dut_state), 64'(IDLE));
        check("rst_wr_ptr", 64'(dut_wr_ptr), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_dmem_we", 64'(bus.dmem_we), 64'd0);
        check("rst_alu_enable", 64'(bus.alu_enable), 64'd0);
        check("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
        check("rst_sleep", 64'(bus.sleep), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        clear = 1'b0;
        tick();

        // single frame
        alu_lat = 20;
        res_l   = 40'h00_0000_1234;
        res_r   = 40'hFF_FFFF_FF00;
        exp_q.push_back({res_l, res_r});
        snap_a = en_rises;
        snap_b = clr_viol;
        send(16'h0010, 16'hFFF0);
        check("t1_state_write", 64'(dut_state), 64'(WRITE));
        check("t1_dmem_we", 64'(bus.dmem_we), 64'h3);
        check("t1_dmem_waddr", 64'(bus.dmem_waddr), 64'd0);
        check("t1_wdata_l", 64'(bus.dmem_wdata_l), 64'h0010);
        check("t1_wdata_r", 64'(bus.dmem_wdata_r), 64'hFFF0);
        tick();
        check("t1_state_clr_l", 64'(dut_state), 64'(CLR_L));
        check("t1_alu_clear", 64'(bus.alu_clear), 64'd1);
        check("t1_cur_addr", 64'(bus.alu_cur_addr), 64'd0);
        check("t1_wr_ptr", 64'(dut_wr_ptr), 64'd1);
        exp_ptr = 8'd1;
        wait_state(PUSH, 100, "t1_reach_push");
        check("t1_out_valid", 64'(bus.out_valid), 64'd1);
        check("t1_out_l", 64'(bus.out_l), 64'h00_0000_1234);
        check("t1_out_r", 64'(bus.out_r), 64'hFF_FFFF_FF00);
        check("t1_two_runs", 64'(en_rises - snap_a), 64'd2);
        check("t1_clear_before_run", 64'(clr_viol - snap_b), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        check("t1_back_idle", 64'(dut_state), 64'(IDLE));
        check("t1_valid_drop", 64'(bus.out_valid), 64'd0);

        // address wrap with out_ready held high
        alu_lat = 2;
        for (int i = 0; i < 257; i++) begin
            res_l = 40'(i);
            res_r = 40'(i) + 40'h100;
            exp_q.push_back({res_l, res_r});
            send(16'(i + 1), 16'h8000);
            check("wrap_waddr", 64'(bus.dmem_waddr), 64'(exp_ptr));
            tick();
            check("wrap_cur_addr", 64'(bus.alu_cur_addr), 64'(exp_ptr));
            exp_ptr = exp_ptr + 8'd1;
            wait_state(IDLE, 50, "wrap_idle");
        end
        check("wrap_wr_ptr", 64'(dut_wr_ptr), 64'(exp_ptr));

        // backpressure: result held for 10 cycles
        bus.out_ready = 1'b0;
        res_l = 40'hAB_CDEF_0123;
        res_r = 40'h12_3456_789A;
        exp_q.push_back({res_l, res_r});
        send(16'h7777, 16'h1111);
        exp_ptr = exp_ptr + 8'd1;
        wait_state(PUSH, 100, "bp_push");
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_l", 64'(bus.out_l), 64'hAB_CDEF_0123);
            check("bp_out_r", 64'(bus.out_r), 64'h12_3456_789A);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_idle", 64'(dut_state), 64'(IDLE));

        // overrun: three arrivals during one left run
        alu_lat = 20;
        res_l = 40'h11;
        res_r = 40'h22;
        exp_q.push_back({res_l, res_r});
        exp_q.push_back({res_l, res_r});
        snap_a = ov_cnt;
        send(16'h0A0A, 16'h0B0B);
        exp_ptr = exp_ptr + 8'd1;
        wait_state(RUN_L, 10, "ov_run_l");
        send(16'h0C0C, 16'h0D0D);
        send(16'h0E0E, 16'h0F0F);
        ticks(3);
        check("ov_one_pulse", 64'(ov_cnt - snap_a), 64'd1);
        wait_state(WRITE, 100, "ov_pending_write");
        check("ov_pend_l", 64'(bus.dmem_wdata_l), 64'h0C0C);
        check("ov_pend_r", 64'(bus.dmem_wdata_r), 64'h0D0D);
        check("ov_pend_addr", 64'(bus.dmem_waddr), 64'(exp_ptr));
        exp_ptr = exp_ptr + 8'd1;
        wait_state(IDLE, 100, "ov_idle");
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (dut_state != IDLE) bad++;
            tick();
        end
        check("ov_third_dropped", 64'(bad), 64'd0);
        check("ov_still_one", 64'(ov_cnt - snap_a), 64'd1);

        // ALU timeout on the left channel
        alu_hang = 1'b1;
        res_r = 40'h33;
        exp_q.push_back({40'h0, res_r});
        snap_a = en_high;
        send(16'h0123, 16'h0456);
        exp_ptr = exp_ptr + 8'd1;
        check("to_err_before", 64'(bus.timeout_err), 64'd0);
        wait_state(CLR_R, 4200, "to_clr_r");
        check("to_run_len", 64'(en_high - snap_a), 64'd4095);
        check("to_err_set", 64'(bus.timeout_err), 64'd1);
        check("to_out_l_zero", 64'(bus.out_l), 64'd0);
        alu_hang = 1'b0;
        wait_state(IDLE, 100, "to_idle");
        check("to_err_sticky", 64'(bus.timeout_err), 64'd1);

        // sleep after 800 zero frames
        alu_lat = 1;
        res_l = 40'h5;
        res_r = 40'h6;
        for (int i = 0; i < 800; i++) begin
            if (i < 799) exp_q.push_back({res_l, res_r});
            send(16'h0, 16'h0);
            exp_ptr = exp_ptr + 8'd1;
            if (i < 799) wait_state(IDLE, 50, "sl_idle");
            else         wait_state(SLEEP, 10, "sl_enter");
        end
        check("sl_sleep_high", 64'(bus.sleep), 64'd1);
        snap_a = en_rises;
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back({40'h0, 40'h0});
            send(16'h0, 16'h0);
            exp_ptr = exp_ptr + 8'd1;
            check("sl_sleep_hold", 64'(bus.sleep), 64'd1);
            wait_state(SLEEP, 20, "sl_zero_back");
        end
        check("sl_no_alu", 64'(en_rises - snap_a), 64'd0);
        check("sl_wr_ptr", 64'(dut_wr_ptr), 64'(exp_ptr));
        res_l = 40'h77;
        res_r = 40'h88;
        exp_q.push_back({res_l, res_r});
        send(16'h0001, 16'h0);
        exp_ptr = exp_ptr + 8'd1;
        check("sl_wake_write", 64'(dut_state), 64'(WRITE));
        tick();
        check("sl_wake_clr_l", 64'(dut_state), 64'(CLR_L));
        check("sl_wake_sleep_low", 64'(bus.sleep), 64'd0);
        wait_state(IDLE, 50, "sl_wake_idle");
        check("sl_wake_alu_runs", 64'(en_rises - snap_a), 64'd2);

        // asynchronous clear in the middle of the right run
        alu_lat = 20;
        res_l = 40'h99;
        send(16'h4444, 16'h5555);
        wait_state(RUN_R, 100, "rst_run_r");
        ticks(5);
        #2;
        clear = 1'b1;
        #1;
        check("arst_state", 64'(dut_state), 64'(IDLE));
        check("arst_alu_enable", 64'(bus.alu_enable), 64'd0);
        check("arst_alu_chan", 64'(bus.alu_chan), 64'd0);
        check("arst_out_l", 64'(bus.out_l), 64'd0);
        check("arst_out_r", 64'(bus.out_r), 64'd0);
        check("arst_timeout_err", 64'(bus.timeout_err), 64'd0);
        check("arst_wr_ptr", 64'(dut_wr_ptr), 64'd0);
        check("arst_cur_addr", 64'(bus.alu_cur_addr), 64'd0);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        clear = 1'b0;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.out_valid) bad++;
            tick();
        end
        check("arst_no_valid_after", 64'(bad), 64'd0);

        check("sb_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msdap_alu_scheduler.md
Name: msdap_alu_scheduler

Overview:
- Frame-level controller for the shared 40-bit filter ALU in the stereo MSDAP datapath.
- Accepts one stereo sample pair per frame and writes both samples into the circular data memories.
- Runs the ALU once for the left channel, then once for the right, and captures both 40-bit results.
- Presents the result pair on a valid/ready output port; also handles overrun, ALU timeout, and zero-input sleep.

Parameters:
- DATA_W, 16, sample width.
- ACC_W, 40, ALU result width.
- ADDR_W, 8, data-memory address width (256-entry circular buffer per channel).
- ZERO_RUN, 800, consecutive all-zero frames before entering sleep.
- TIMEOUT, 4095, maximum cycles to wait for alu_output_en.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- clear  in  1  reset; asynchronous, active-high.
- sample_valid  in  1  one-cycle strobe: a new stereo pair is present.
- sample_l  in  DATA_W  left-channel sample.
- sample_r  in  DATA_W  right-channel sample.
- dmem_we  out  2  write enables, bit0 = left bank, bit1 = right bank.
- dmem_waddr  out  ADDR_W  shared write address.
- dmem_wdata_l  out  DATA_W  left write data.
- dmem_wdata_r  out  DATA_W  right write data.
- alu_clear  out  1  one-cycle ALU accumulator clear before each run.
- alu_enable  out  1  held high while the ALU runs.
- alu_chan  out  1  0 = left, 1 = right; selects the coeff/rj bank.
- alu_cur_addr  out  ADDR_W  address of the newest sample.
- alu_output_en  in  1  ALU done strobe.
- alu_result  in  ACC_W  ALU result; valid with alu_output_en.
- out_valid  out  1  result pair available.
- out_ready  in  1  consumer accepts the pair.
- out_l  out  ACC_W  left result.
- out_r  out  ACC_W  right result.
- overrun  out  1  one-cycle pulse: a frame was dropped.
- timeout_err  out  1  sticky; cleared only by clear.
- sleep  out  1  high while in sleep mode.

Behaviour:
- Reset: every output is 0, wr_ptr = 0, zero counter = 0, pending flag = 0, state = IDLE. Reset mid-run aborts immediately with no partial output.
- IDLE, on sample_valid or pending:
  - Go to WRITE.
  - The pair comes from the pending latch if pending is set; pending has priority and is cleared.
- WRITE (1 cycle):
  - dmem_we = 2'b11, dmem_waddr = wr_ptr, write data = latched pair.
  - alu_cur_addr <= wr_ptr; wr_ptr increments, wrapping 255 -> 0.
  - Zero counter: if both samples are 0, increment, saturating at ZERO_RUN; otherwise reset to 0.
  - Next state: SLEEP if the counter is now ZERO_RUN, else CLR_L.
- CLR_L (1 cycle): alu_clear = 1, alu_chan = 0. Next state RUN_L.
- RUN_L:
  - alu_enable = 1, alu_chan = 0, wait counter counts up.
  - On alu_output_en: capture alu_result into out_l, go to CLR_R.
  - If the wait counter reaches TIMEOUT: out_l <= 0, timeout_err <= 1, go to CLR_R.
- CLR_R / RUN_R: same as CLR_L / RUN_L with alu_chan = 1 and capture into out_r. RUN_R exits to PUSH.
- alu_enable drops in the cycle after alu_output_en is seen. Latency from sample_valid to out_valid is 3 + (left ALU cycles) + (right ALU cycles) + 1.
- PUSH:
  - out_valid = 1 and out_l/out_r held stable until out_ready.
  - The handshake completes in the cycle where out_valid and out_ready are both 1; out_valid deasserts the next cycle and the FSM returns to IDLE.
- SLEEP:
  - sleep = 1; ALU outputs stay idle.
  - Each sample_valid is written exactly as in WRITE, so the buffer stays current.
  - If both samples are 0: push out_l = out_r = 0 through PUSH, then return to SLEEP.
  - If either sample is non-zero: clear the zero counter, sleep <= 0, go to CLR_L with that pair already written.
- Busy arrivals (any state other than IDLE, or SLEEP waiting for sample_valid):
  - sample_valid is latched into the pending slot if pending is empty.
  - If pending is already full, the frame is discarded and overrun pulses for 1 cycle.
  - Simultaneous out_ready handshake and sample_valid: the sample goes to pending and is consumed in the next IDLE cycle.
- An alu_output_en outside RUN_L/RUN_R is ignored.

Decomposition:
- msdap_pkg holds:
  - the state enum (IDLE, WRITE, CLR_L, RUN_L, CLR_R, RUN_R, PUSH, SLEEP);
  - the DATA_W/ACC_W/ADDR_W constants;
  - the channel enum (CH_L = 0, CH_R = 1).
- Sub-module zero_run_detector: saturating counter with a reached flag, parameterised by ZERO_RUN.

Test Plan:
- Single frame: L = 0x0010, R = 0xFFF0 after reset; ALU model returns 0x00_0000_1234 (L) and 0xFF_FFFF_FF00 (R) after 20 cycles each. Expect dmem_waddr = 0 and alu_cur_addr = 0; alu_clear precedes each run; out_valid with exactly those values; wr_ptr = 1.
- Wrap and backpressure: 257 frames with out_ready tied high. Expect frame 256 written at address 0 and alu_cur_addr = 0. Then hold out_ready low for 10 cycles: out_l/out_r stable and out_valid high throughout.
- Overrun: three sample_valid strobes during one RUN_L. Expect the 2nd frame pending and processed next, and the 3rd frame dropped with exactly one overrun pulse.
- Timeout: ALU model never asserts output_en. Expect RUN_L exits after TIMEOUT cycles, out_l = 0, timeout_err = 1, right channel still runs.
- Sleep: 800 all-zero frames -> sleep = 1, alu_enable never rises again, each further zero frame pushes 0/0. A frame with L = 0x0001 -> sleep = 0 and CLR_L follows WRITE.
- Reset during RUN_R: assert clear asynchronously. Expect all outputs 0 within the same cycle, IDLE, wr_ptr = 0, no out_valid afterwards.
